fetch_unit: RTL and testbench

//  Instruction-fetch stage: owns the PC, issues single-outstanding requests to instruction

---
 rtl/fetch_pkg.sv | 9 +
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} fetch_state_t;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, keeps one imem request in flight and hands
// {pc, instr} to the IF/ID register over a valid/ready handshake.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_instr
);

    fetch_state_t    state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic            kill, kill_n;
    logic            out_valid_n;
    logic [XLEN-1:0] out_pc_n;
    logic [ILEN-1:0] out_instr_n;
    logic [XLEN-1:0] redirect_target;

    // Targets are always word aligned; the low two bits are dropped.
    assign redirect_target = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};

    assign imem_req  = (state == IDLE) && en && !redirect;
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            kill      <= 1'b0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_instr <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            kill      <= kill_n;
            out_valid <= out_valid_n;
            out_pc    <= out_pc_n;
            out_instr <= out_instr_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        kill_n      = kill;
        out_valid_n = out_valid;
        out_pc_n    = out_pc;
        out_instr_n = out_instr;
        case (state)
            IDLE: begin
                if (redirect) begin
                    pc_n = redirect_target;
                end else if (en) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    // A redirect arriving with the response squashes it just like kill.
                    if (kill || redirect) begin
                        kill_n  = 1'b0;
                        state_n = IDLE;
                        if (redirect) pc_n = redirect_target;
                    end else begin
                        out_instr_n = imem_rdata;
                        out_pc_n    = pc;
                        out_valid_n = 1'b1;
                        pc_n        = pc + XLEN'(INSTR_BYTES);
                        state_n     = HOLD;
                    end
                end else if (redirect) begin
                    pc_n   = redirect_target;
                    kill_n = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    out_valid_n = 1'b0;
                    pc_n        = redirect_target;
                    state_n     = IDLE;
                end else if (out_ready) begin
                    out_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: bus-level memory model plus a queue of expected IF/ID transfers.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        en;
    logic        imem_req, w_req;
    logic [31:0] imem_addr, w_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid, w_out_valid;
    logic        out_ready;
    logic [31:0] out_pc, w_out_pc;
    logic [31:0] out_instr, w_out_instr;

    fetch_unit u_dut (
        .clk(clk), .rst(rst), .en(en),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .rst(rst), .en(en),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(w_out_valid), .out_ready(out_ready),
        .out_pc(w_out_pc), .out_instr(w_out_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_hs     = 0;

    logic [31:0] q_pc[$];
    logic [31:0] q_instr[$];

    // memory model state
    int          mem_lat  = 1;
    logic        mem_dead = 1'b0;
    logic        pend     = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_data;

    // values sampled mid-cycle
    logic        smp_req, smp_valid, smp_wreq, smp_wvalid;
    logic [31:0] smp_addr, smp_pc, smp_instr, smp_waddr, smp_wpc, smp_winstr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0013_0000;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_xfer(input logic [31:0] pc);
        q_pc.push_back(pc);
        q_instr.push_back(mem_word(pc));
    endtask

    // One clock cycle: sample mid-cycle, score any transfer, then answer memory after the edge.
    task automatic tick();
        logic        req_seen;
        logic [31:0] a;
        logic [31:0] e_pc, e_instr;
        #2;
        req_seen   = imem_req;
        a          = imem_addr;
        smp_req    = imem_req;   smp_addr  = imem_addr;
        smp_valid  = out_valid;  smp_pc    = out_pc;   smp_instr  = out_instr;
        smp_wreq   = w_req;      smp_waddr = w_addr;
        smp_wvalid = w_out_valid; smp_wpc  = w_out_pc; smp_winstr = w_out_instr;
        if (out_valid && out_ready && !redirect) begin
            n_hs++;
            if (q_pc.size() == 0) begin
                check_val("sb_underflow_pc", out_pc, 32'hxxxx_xxxx);
            end else begin
                e_pc    = q_pc.pop_front();
                e_instr = q_instr.pop_front();
                check_val("sb_out_pc", out_pc, e_pc);
                check_val("sb_out_instr", out_instr, e_instr);
            end
        end
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (req_seen) begin
            pend      = 1'b1;
            pend_cnt  = mem_lat;
            pend_data = mem_dead ? 32'h0000_DEAD : mem_word(a);
        end
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = pend_data;
                pend        = 1'b0;
            end
        end
    endtask

    initial begin
        int hs_before;
        rst = 1'b0; en = 1'b0; redirect = 1'b0; redirect_pc = '0;
        out_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        repeat (2) @(posedge clk);
        #3;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_pc", out_pc, 0);
        check_val("rst_out_instr", out_instr, 0);
        check_val("rst_pc", imem_addr, 0);
        check_val("rst_wrap_pc", w_addr, 32'hFFFF_FFFC);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Streaming fetch with a one-cycle memory
        en = 1'b1;
        expect_xfer(32'h0); expect_xfer(32'h4); expect_xfer(32'h8);
        for (int i = 0; i < 9; i++) begin
            tick();
            check_val($sformatf("stream_valid_%0d", i), smp_valid, (i % 3 == 2));
            if (i == 0) begin
                check_val("first_addr", smp_addr, 32'h0);
                check_val("first_req", smp_req, 1);
                check_val("wrap_first_addr", smp_waddr, 32'hFFFF_FFFC);
                check_val("wrap_first_req", smp_wreq, 1);
            end
            if (i == 2) begin
                check_val("wrap_out_valid", smp_wvalid, 1);
                check_val("wrap_out_pc", smp_wpc, 32'hFFFF_FFFC);
                check_val("wrap_out_instr", smp_winstr, mem_word(32'h0));
            end
            if (i == 3) begin
                check_val("second_addr", smp_addr, 32'h4);
                check_val("wrap_second_addr", smp_waddr, 32'h0);
            end
        end

        // Backpressure in HOLD
        out_ready = 1'b0;
        expect_xfer(32'hC);
        tick();
        check_val("bp_addr", smp_addr, 32'hC);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("bp_valid", smp_valid, 1);
            check_val("bp_pc", smp_pc, 32'hC);
            check_val("bp_instr", smp_instr, mem_word(32'hC));
            check_val("bp_no_req", smp_req, 0);
        end
        out_ready = 1'b1;
        mem_lat   = 2;
        mem_dead  = 1'b1;
        tick();
        tick();
        check_val("bp_idle_req", smp_req, 1);
        check_val("bp_idle_addr", smp_addr, 32'h10);

        // Redirect while waiting; the late response must be discarded
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        check_val("wait_redir_no_req", smp_req, 0);
        redirect = 1'b0; mem_dead = 1'b0; mem_lat = 1;
        check_val("dead_rvalid_seen", imem_rvalid, 1);
        tick();
        check_val("squash_valid", smp_valid, 0);
        expect_xfer(32'h100);
        tick();
        check_val("redir_req", smp_req, 1);
        check_val("redir_addr", smp_addr, 32'h100);
        tick();
        tick();

        // Redirect in HOLD beats the handshake; unaligned target is aligned down
        tick();
        check_val("hold_pre_addr", smp_addr, 32'h104);
        tick();
        redirect = 1'b1; redirect_pc = 32'h103; out_ready = 1'b1;
        hs_before = n_hs;
        tick();
        check_val("hold_redir_valid", smp_valid, 1);
        redirect = 1'b0;
        check_val("hold_redir_no_hs", n_hs, hs_before);
        expect_xfer(32'h100);
        tick();
        check_val("hold_redir_drop", smp_valid, 0);
        check_val("hold_redir_addr", smp_addr, 32'h100);
        tick();
        tick();

        // Asynchronous reset while a request is in flight
        mem_lat = 3;
        tick();
        check_val("rst_mid_addr", smp_addr, 32'h104);
        rst = 1'b0; en = 1'b0;
        #1;
        check_val("rst_mid_valid", out_valid, 0);
        check_val("rst_mid_pc", imem_addr, 32'h0);
        check_val("rst_mid_out_pc", out_pc, 0);
        tick();
        rst = 1'b1;
        tick();
        check_val("late_rvalid_seen", imem_rvalid, 1);
        tick();
        check_val("late_resp_valid", smp_valid, 0);
        tick();
        check_val("late_resp_valid2", smp_valid, 0);
        check_val("late_resp_no_req", smp_req, 0);
        en = 1'b1; mem_lat = 1;
        expect_xfer(32'h0);
        tick();
        check_val("restart_addr", smp_addr, 32'h0);
        check_val("restart_req", smp_req, 1);
        tick();
        tick();
        en = 1'b0;
        tick();
        tick();
        check_val("sb_empty", q_pc.size(), 0);
        check_val("hs_total", n_hs, 7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
